// File: rtl/tinynpu_lane_array_if.sv
// Host/stream bundle for tinynpu_lane_array: activation and weight load
// channels, job control, and the requantised result stream.
interface tinynpu_lane_array_if #(
  parameter int LANES = 4,
  parameter int NBITS = 8,
  parameter int DEPTH = 8
);
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LENW = $clog2(DEPTH + 1);

  logic [NBITS-1:0] x_in;
  logic             x_val;
  logic             x_rdy;
  logic [NBITS-1:0] w_in;
  logic [LW-1:0]    w_sel;
  logic             w_val;
  logic             w_rdy;
  logic             start;
  logic [LENW-1:0]  len;
  logic             busy;
  logic [NBITS-1:0] z_out;
  logic [LW-1:0]    z_lane;
  logic             z_val;
  logic             z_rdy;

  modport master (
    output x_in, x_val, w_in, w_sel, w_val, start, len, z_rdy,
    input  x_rdy, w_rdy, busy, z_out, z_lane, z_val
  );

  modport slave (
    input  x_in, x_val, w_in, w_sel, w_val, start, len, z_rdy,
    output x_rdy, w_rdy, busy, z_out, z_lane, z_val
  );
endinterface

// File: rtl/tinynpu_lane_array.sv
// tinynpu_lane_array: LANES signed MAC lanes, one weight FIFO per lane, one
// broadcast activation FIFO, and a sequencer that runs a dot product then
// streams the requantised lane results out one lane at a time.
// Build option: TINYNPU_RELU_EN clamps negative results to zero.
//
// state     | meaning
// S_IDLE    | waiting for start with a non-zero len
// S_COMPUTE | one MAC step per cycle whenever every FIFO has data
// S_DRAIN   | presenting lane k result until accepted, k = 0..LANES-1
module tinynpu_lane_array #(
  parameter int LANES   = 4,
  parameter int NBITS   = 8,
  parameter int ACCBITS = 20,
  parameter int DEPTH   = 8,
  parameter int SHIFT   = 4
) (
  input logic clk,
  input logic rst,
  tinynpu_lane_array_if.slave bus
);
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LENW = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic signed [ACCBITS-1:0] ZMAX = ACCBITS'((2 ** (NBITS - 1)) - 1);
  localparam logic signed [ACCBITS-1:0] ZMIN = ~ZMAX;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [NBITS-1:0] x_mem [DEPTH];
  logic [PW-1:0]    x_wp, x_rp;
  logic [LENW-1:0]  x_cnt;
  logic [NBITS-1:0] w_mem [LANES][DEPTH];
  logic [PW-1:0]    w_wp [LANES];
  logic [PW-1:0]    w_rp [LANES];
  logic [LENW-1:0]  w_cnt [LANES];

  logic [LENW-1:0]           cnt;
  logic [LW-1:0]             k;
  logic signed [ACCBITS-1:0] acc [LANES];

  logic                      x_push, all_w_ne, step, accept_start;
  logic [LANES-1:0]          w_push;
  logic signed [2*NBITS-1:0] prod [LANES];
  logic signed [ACCBITS-1:0] prod_ext [LANES];
  logic signed [ACCBITS-1:0] acc_sh;
  logic [NBITS-1:0]          zq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready is forced low while reset is asserted, not just after the first edge.
  assign bus.x_rdy = rst & (x_cnt != LENW'(DEPTH));
  assign bus.w_rdy = rst & (w_cnt[bus.w_sel] != LENW'(DEPTH));
  assign x_push    = bus.x_val & bus.x_rdy;

  // Weight push decode and "all lanes have data" reduction.
  always_comb begin
    w_push   = '0;
    all_w_ne = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      w_push[i] = bus.w_val & bus.w_rdy & (bus.w_sel == LW'(i));
      if (w_cnt[i] == '0) all_w_ne = 1'b0;
    end
  end

  assign step         = (state == S_COMPUTE) & (x_cnt != '0) & all_w_ne;
  assign accept_start = (state == S_IDLE) & bus.start & (bus.len != '0);

  // FIFO storage needs no reset; emptiness is tracked by the counters.
  always_ff @(posedge clk) begin
    if (x_push) x_mem[x_wp] <= bus.x_in;
    for (int i = 0; i < LANES; i++)
      if (w_push[i]) w_mem[i][w_wp[i]] <= bus.w_in;
  end

  // Activation FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_wp  <= '0;
      x_rp  <= '0;
      x_cnt <= '0;
    end else begin
      if (x_push) x_wp <= ptr_inc(x_wp);
      if (step)   x_rp <= ptr_inc(x_rp);
      x_cnt <= x_cnt + LENW'(x_push) - LENW'(step);
    end
  end

  // Per-lane weight FIFO pointers and occupancy; all lanes pop together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        w_wp[i]  <= '0;
        w_rp[i]  <= '0;
        w_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_push[i]) w_wp[i] <= ptr_inc(w_wp[i]);
        if (step)      w_rp[i] <= ptr_inc(w_rp[i]);
        w_cnt[i] <= w_cnt[i] + LENW'(w_push[i]) - LENW'(step);
      end
    end
  end

  // Full-precision signed products of the FIFO heads, sign-extended to the accumulator.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i]     = $signed(x_mem[x_rp]) * $signed(w_mem[i][w_rp[i]]);
      prod_ext[i] = {{(ACCBITS - 2 * NBITS){prod[i][2*NBITS-1]}}, prod[i]};
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept_start) state_nxt = S_COMPUTE;
      S_COMPUTE: if (step && cnt == LENW'(1)) state_nxt = S_DRAIN;
      S_DRAIN:   if (bus.z_rdy && k == LW'(LANES - 1)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Step down-counter, drain lane index and accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      k   <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      if (accept_start) begin
        cnt <= bus.len;
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else if (step) begin
        cnt <= cnt - 1'b1;
        for (int i = 0; i < LANES; i++) acc[i] <= acc[i] + prod_ext[i];
      end
      if (state == S_DRAIN && bus.z_rdy)
        k <= (k == LW'(LANES - 1)) ? '0 : k + 1'b1;
    end
  end

  // Requantise the selected lane: arithmetic shift, then clamp to NBITS.
  always_comb begin
    acc_sh = acc[k] >>> SHIFT;
    if (acc_sh > ZMAX)      zq = ZMAX[NBITS-1:0];
    else if (acc_sh < ZMIN) zq = ZMIN[NBITS-1:0];
    else                    zq = acc_sh[NBITS-1:0];
`ifdef TINYNPU_RELU_EN
    if (zq[NBITS-1]) zq = '0;
`else
    zq = zq;
`endif
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.z_val  = (state == S_DRAIN);
  assign bus.z_out  = bus.z_val ? zq : '0;
  assign bus.z_lane = bus.z_val ? k : '0;
endmodule

// File: tb/tb_tinynpu_lane_array.sv
module tb_tinynpu_lane_array;
  localparam int LANES = 4, NBITS = 8, ACCBITS = 20, DEPTH = 8, SHIFT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   waited;

  always #5 clk = ~clk;

  tinynpu_lane_array_if #(.LANES(LANES), .NBITS(NBITS), .DEPTH(DEPTH)) bus ();

  tinynpu_lane_array #(
    .LANES(LANES), .NBITS(NBITS), .ACCBITS(ACCBITS), .DEPTH(DEPTH), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] v);
`ifdef TINYNPU_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  // All drive tasks are entered and left on a falling edge.
  task automatic push_x(input logic [7:0] v);
    bus.x_in = v; bus.x_val = 1'b1;
    @(negedge clk);
    bus.x_val = 1'b0;
  endtask

  task automatic push_w(input int lane, input logic [7:0] v);
    bus.w_sel = 2'(lane); bus.w_in = v; bus.w_val = 1'b1;
    @(negedge clk);
    bus.w_val = 1'b0;
  endtask

  task automatic start_job(input int l);
    bus.start = 1'b1; bus.len = 4'(l);
    @(negedge clk);
    bus.start = 1'b0; bus.len = '0;
  endtask

  task automatic wait_zval(input int max_c, output int n);
    n = 0;
    while (bus.z_val !== 1'b1 && n < max_c) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Expects z_rdy=1; optionally pulses start during the final accept.
  task automatic drain_chk(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input bit start_last);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < LANES; i++) begin
      chk({tag, "_zval"}, 32'(bus.z_val), 32'd1);
      chk({tag, "_lane"}, 32'(bus.z_lane), 32'(i));
      chk({tag, "_zout"}, 32'(bus.z_out), 32'(e[i]));
      if (start_last && i == LANES - 1) begin
        bus.start = 1'b1; bus.len = 4'd1;
      end
      @(negedge clk);
      bus.start = 1'b0; bus.len = '0;
    end
    chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.x_in = '0; bus.x_val = 1'b0; bus.w_in = '0; bus.w_sel = '0; bus.w_val = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.z_rdy = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_x_rdy", 32'(bus.x_rdy), 32'd0);
    chk("rst_w_rdy", 32'(bus.w_rdy), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_zval", 32'(bus.z_val), 32'd0);
    chk("rst_zout", 32'(bus.z_out), 32'd0);
    chk("rst_zlane", 32'(bus.z_lane), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_x_rdy", 32'(bus.x_rdy), 32'd1);
    chk("rel_w_rdy", 32'(bus.w_rdy), 32'd1);

    // Basic dot: x={4,8}, w lane i={4i,4i+4}, >>>4 gives {2,5,8,11}
    push_x(8'd4); push_x(8'd8);
    for (int l = 0; l < LANES; l++) begin
      push_w(l, 8'(4 * l)); push_w(l, 8'(4 * (l + 1)));
    end
    bus.z_rdy = 1'b1;
    start_job(2);
    chk("basic_busy", 32'(bus.busy), 32'd1);
    wait_zval(40, waited);
    chk("basic_lat", 32'(waited), 32'd2);
    drain_chk("basic", 8'd2, 8'd5, 8'd8, 8'd11, 1'b1);

    // Stall: lane 3 empty holds the step until its weight arrives
    push_x(8'd16);
    for (int l = 0; l < 3; l++) push_w(l, 8'd16);
    start_job(1);
    repeat (3) @(negedge clk);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    chk("stall_zval", 32'(bus.z_val), 32'd0);
    push_w(3, 8'd16);
    wait_zval(40, waited);
    chk("stall_lat", 32'(waited), 32'd1);
    drain_chk("stall", 8'h10, 8'h10, 8'h10, 8'h10, 1'b0);

    // FIFO full + saturation/shift across pointer wrap
    for (int j = 0; j < DEPTH; j++) push_x(8'd127);
    chk("x_full_rdy", 32'(bus.x_rdy), 32'd0);
    push_x(8'h55);
    chk("x_extra_rdy", 32'(bus.x_rdy), 32'd0);
    for (int j = 0; j < DEPTH; j++) begin
      push_w(0, 8'd127); push_w(1, 8'h80); push_w(2, 8'd1); push_w(3, 8'hff);
    end
    bus.w_sel = 2'd2;
    #1;
    chk("w_full_rdy", 32'(bus.w_rdy), 32'd0);
    @(negedge clk);
    start_job(8);
    wait_zval(80, waited);
    chk("sat1_lat", 32'(waited), 32'd8);
    drain_chk("sat1", 8'h7f, rl(8'h80), 8'h3f, rl(8'hc0), 1'b0);

    // Second full job with backpressure on lane 0
    bus.z_rdy = 1'b0;
    for (int j = 0; j < DEPTH; j++) push_x(8'h80);
    for (int j = 0; j < DEPTH; j++) begin
      push_w(0, 8'd127); push_w(1, 8'h80); push_w(2, 8'd0); push_w(3, 8'd1);
    end
    start_job(8);
    wait_zval(80, waited);
    chk("sat2_lat", 32'(waited), 32'd8);
    for (int c = 0; c < 5; c++) begin
      chk("bp_zval", 32'(bus.z_val), 32'd1);
      chk("bp_lane", 32'(bus.z_lane), 32'd0);
      chk("bp_zout", 32'(bus.z_out), 32'(rl(8'h80)));
      @(negedge clk);
    end
    bus.z_rdy = 1'b1;
    drain_chk("sat2", rl(8'h80), 8'h7f, 8'h00, rl(8'hc0), 1'b0);

    // Reset mid-COMPUTE with three activations queued
    push_x(8'd1); push_x(8'd1); push_x(8'd1);
    start_job(3);
    @(negedge clk);
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_zval", 32'(bus.z_val), 32'd0);
    chk("mid_x_rdy", 32'(bus.x_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_x_rdy", 32'(bus.x_rdy), 32'd1);
    chk("post_w_rdy", 32'(bus.w_rdy), 32'd1);
    push_x(8'd16);
    for (int l = 0; l < LANES; l++) push_w(l, 8'd16);
    start_job(1);
    wait_zval(40, waited);
    chk("post_lat", 32'(waited), 32'd1);
    drain_chk("post", 8'h10, 8'h10, 8'h10, 8'h10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
